// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch master and a data master onto one memory bus.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round robin; the default is fixed data priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  output logic [15:0] data_m_data_in,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);
  typedef enum logic [1:0] {IDLE, GRANT_INSTR, GRANT_DATA} state_t;
  state_t r_state;
  logic r_mask_i, r_mask_d;
  logic w_el_i, w_el_d, w_pick_d, w_gi, w_gd;
  assign w_el_i = instr_m_access & ~r_mask_i;
  assign w_el_d = data_m_access & ~r_mask_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic r_last_i;
  // r_last_i high means the fetch master won last, so data goes first on a tie
  assign w_pick_d = w_el_d & (~w_el_i | r_last_i);
`else
  assign w_pick_d = w_el_d;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mask_i <= 1'b0;
      r_mask_d <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      r_last_i <= 1'b1;
`endif
    end else begin
      r_mask_i <= r_state == GRANT_INSTR && q_m_ack;
      r_mask_d <= r_state == GRANT_DATA && q_m_ack;
      case (r_state)
        IDLE:                    r_state <= w_pick_d ? GRANT_DATA : w_el_i ? GRANT_INSTR : IDLE;
        GRANT_INSTR, GRANT_DATA: if (q_m_ack) r_state <= IDLE;
        default:                 r_state <= IDLE;
      endcase
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (r_state == IDLE && (w_el_i || w_el_d)) r_last_i <= ~w_pick_d;
`endif
    end
  end
  assign w_gi = r_state == GRANT_INSTR && !reset;
  assign w_gd = r_state == GRANT_DATA && !reset;
  assign q_m_access      = w_gi | w_gd;
  assign q_m_addr        = w_gd ? data_m_addr : w_gi ? instr_m_addr : '0;
  assign q_m_data_out    = w_gd ? data_m_data_out : '0;
  assign q_m_wr_en       = w_gd & data_m_wr_en;
  assign q_m_bytesel     = w_gd ? data_m_bytesel : w_gi ? 2'b11 : 2'b00;
  assign instr_m_ack     = w_gi & q_m_ack;
  assign data_m_ack      = w_gd & q_m_ack;
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;
endmodule
